// File: rtl/regbank_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_wr_arbiter_pkg
// Brief    : Shared CPU constants for the register-bank write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regbank_wr_arbiter_pkg;

    // Two-state write FSM encoding
    localparam int         c_state_w   = 1;
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_write  = 1'b1;

    // Register 3 is the hard-wired constant generator; writes to it are dropped
    localparam int c_const_reg = 3;

    // Requester IDs
    localparam int c_req_pc     = 0;
    localparam int c_req_alu    = 1;
    localparam int c_req_loader = 2;

    // Index width that stays legal for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regbank_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin winner select with optional fixed
//            priority for requester 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import regbank_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             pri_en,
    output logic             valid,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : p_pick
        int               pos;
        logic [IDX_W-1:0] cand;
        pos   = 0;
        cand  = '0;
        valid = 1'b0;
        idx   = '0;
        // Walk from rr_ptr, wrapping modulo NREQ; first set request wins
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            cand = IDX_W'(pos);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (pri_en && req[c_req_pc]) begin
            valid = 1'b1;
            idx   = IDX_W'(c_req_pc);
        end
        gnt = valid ? (NREQ'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/regbank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_wr_arbiter
// Brief    : Arbitrates register-bank writes from NREQ requesters, one write
//            per two cycles. Define REGARB_PC_PRIORITY_EN to give requester 0
//            fixed priority over the round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_wr_arbiter
    import regbank_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int NREQ   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*REG_W-1:0]   req_reg,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    wr_en,
    output logic [REG_W-1:0]        wr_reg,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam int c_idx_w = idx_width(NREQ);

`ifdef REGARB_PC_PRIORITY_EN
    localparam logic c_pri_en = 1'b1;
`else
    localparam logic c_pri_en = 1'b0;
`endif

    logic [c_state_w-1:0] state_q, state_d;
    logic [c_idx_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REG_W-1:0]     wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic                 pick_valid;
    logic [NREQ-1:0]      pick_gnt;
    logic [c_idx_w-1:0]   pick_idx;
    logic                 w_drop;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pri_en (c_pri_en),
        .valid  (pick_valid),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    // The latched target decides whether the pending write is dropped
    assign w_drop = (wr_reg_q == REG_W'(c_const_reg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_st_idle;
            rr_ptr_q   <= '0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            c_st_idle: begin
                if (pick_valid) begin
                    state_d   = c_st_write;
                    rr_ptr_d  = (pick_idx == c_idx_w'(NREQ - 1)) ? '0
                                                                 : pick_idx + c_idx_w'(1);
                    wr_reg_d  = req_reg[pick_idx*REG_W +: REG_W];
                    wr_data_d = req_data[pick_idx*DATA_W +: DATA_W];
                end
            end
            c_st_write: begin
                state_d = c_st_idle;
                if (w_drop && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // rst gates gnt directly so a grant never leaks while reset is held
    always_comb begin
        gnt      = ((state_q == c_st_idle) && !rst) ? pick_gnt : '0;
        busy     = (state_q == c_st_write);
        wr_en    = (state_q == c_st_write) && !w_drop;
        wr_reg   = wr_reg_q;
        wr_data  = wr_data_q;
        drop_cnt = drop_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_regbank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_wr_arbiter
// Brief    : Directed self-checking bench for regbank_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regbank_wr_arbiter;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int NREQ   = 3;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*REG_W-1:0]  req_reg;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   wr_en;
    logic [REG_W-1:0]       wr_reg;
    logic [DATA_W-1:0]      wr_data;
    logic                   busy;
    logic [7:0]             drop_cnt;

    int checks = 0;
    int errors = 0;

    regbank_wr_arbiter #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .NREQ   (NREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_reg  (req_reg),
        .req_data (req_data),
        .gnt      (gnt),
        .wr_en    (wr_en),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #3;
        rst = 1'b0;
    endtask

    task automatic set_slot(input int i, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        req_reg[i*REG_W +: REG_W]    = r;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        req = 3'b111;
        #2;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (wr_reg !== 4'd0) begin errors++; $display("FAIL reset_wr_reg got %0d exp 0", wr_reg); end
        checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0000", wr_data); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
        do_reset();
    endtask

    task automatic test_single_write();
        tick();
        set_slot(0, 4'd5, 16'hBEEF);
        req = 3'b001;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b exp 001", gnt); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_c0 got %b exp 0", wr_en); end
        tick();
        req = 3'b000;
        #1;
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en_c1 got %b exp 1", wr_en); end
        checks++; if (wr_reg !== 4'd5) begin errors++; $display("FAIL single_wr_reg got %0d exp 5", wr_reg); end
        checks++; if (wr_data !== 16'hBEEF) begin errors++; $display("FAIL single_wr_data got %h exp beef", wr_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL single_gnt_c1 got %b exp 000", gnt); end
        tick();
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle_again got wr_en=%b busy=%b exp 0 0", wr_en, busy); end
        checks++; if (wr_reg !== 4'd5 || wr_data !== 16'hBEEF) begin errors++; $display("FAIL single_hold got %0d/%h exp 5/beef", wr_reg, wr_data); end
    endtask

`ifndef REGARB_PC_PRIORITY_EN
    task automatic test_round_robin();
        logic [2:0] exp_gnt [8];
        logic [3:0] exp_reg [8];
        exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        exp_reg = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd4, 4'd0, 4'd1};
        do_reset();
        tick();
        set_slot(0, 4'd1, 16'hA000);
        set_slot(1, 4'd2, 16'hA001);
        set_slot(2, 4'd4, 16'hA002);
        req = 3'b111;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (gnt !== exp_gnt[c]) begin errors++; $display("FAIL rr_gnt cycle %0d got %b exp %b", c, gnt, exp_gnt[c]); end
            if (c % 2 == 1) begin
                checks++;
                if (wr_en !== 1'b1 || wr_reg !== exp_reg[c]) begin
                    errors++; $display("FAIL rr_write cycle %0d got wr_en=%b reg=%0d exp 1 %0d", c, wr_en, wr_reg, exp_reg[c]);
                end
            end
            tick();
        end
        req = 3'b000;
    endtask
`else
    task automatic test_pc_priority();
        do_reset();
        tick();
        set_slot(0, 4'd1, 16'hB000);
        set_slot(1, 4'd2, 16'hB001);
        set_slot(2, 4'd4, 16'hB002);
        for (int c = 0; c < 8; c++) begin
            req = {2'b11, (c % 2 == 0)};
            #1;
            checks++;
            if (gnt !== ((c % 2 == 0) ? 3'b001 : 3'b000)) begin
                errors++; $display("FAIL pri_gnt cycle %0d got %b", c, gnt);
            end
            tick();
        end
        req = 3'b110;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL pri_rr_others got %b exp 010", gnt); end
        tick();
        req = 3'b000;
        tick();
    endtask
`endif

    task automatic test_const_reg_drop();
        int  ngnt;
        int  nbusy_bad;
        logic any_wr;
        ngnt      = 0;
        nbusy_bad = 0;
        any_wr    = 1'b0;
        do_reset();
        tick();
        set_slot(0, 4'd3, 16'h1111);
        req = 3'b001;
        for (int n = 0; n < 260; n++) begin
            #1;
            if (gnt === 3'b001) ngnt++;
            tick();
            any_wr = any_wr | wr_en;
            if (busy !== 1'b1) nbusy_bad++;
            tick();
            if (n == 0) begin
                checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_first got %0d exp 1", drop_cnt); end
            end
            if (n == 254) begin
                checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_reach_max got %0d exp 255", drop_cnt); end
            end
        end
        req = 3'b000;
        checks++; if (any_wr !== 1'b0) begin errors++; $display("FAIL drop_wr_en got %b exp 0", any_wr); end
        checks++; if (ngnt != 260) begin errors++; $display("FAIL drop_grants got %0d exp 260", ngnt); end
        checks++; if (nbusy_bad != 0) begin errors++; $display("FAIL drop_busy got %0d bad cycles exp 0", nbusy_bad); end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d exp 255", drop_cnt); end
    endtask

    task automatic test_reset_mid_write();
        // rr_ptr is 1 here, so requester 1 wins and rr_ptr moves to 2
        set_slot(1, 4'd7, 16'h1234);
        req = 3'b010;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_gnt got %b exp 010", gnt); end
        tick();
        req = 3'b000;
        #1;
        checks++; if (wr_en !== 1'b1 || wr_reg !== 4'd7) begin errors++; $display("FAIL midrst_pre got wr_en=%b reg=%0d exp 1 7", wr_en, wr_reg); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en got %b exp 0", wr_en); end
        checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL midrst_busy_gnt got %b %b exp 0 000", busy, gnt); end
        checks++; if (wr_reg !== 4'd0 || wr_data !== 16'h0) begin errors++; $display("FAIL midrst_wr got %0d/%h exp 0/0000", wr_reg, wr_data); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_drop_cnt got %0d exp 0", drop_cnt); end
        set_slot(0, 4'd9, 16'h5555);
        set_slot(2, 4'd10, 16'hAAAA);
        req = 3'b101;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL midrst_gnt_in_rst got %b exp 000", gnt); end
        rst = 1'b0;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL postrst_gnt got %b exp 001", gnt); end
        tick();
        req = 3'b000;
        #1;
        checks++; if (wr_en !== 1'b1 || wr_reg !== 4'd9 || wr_data !== 16'h5555) begin
            errors++; $display("FAIL postrst_write got %b %0d %h exp 1 9 5555", wr_en, wr_reg, wr_data);
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_reg  = '0;
        req_data = '0;
        test_reset();
        test_single_write();
`ifndef REGARB_PC_PRIORITY_EN
        test_round_robin();
`else
        test_pc_priority();
`endif
        test_const_reg_drop();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regbank_wr_arbiter.md
REGBANK_WR_ARBITER -- requirements
Module: regbank_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register data width.
REQ-002 The block SHALL have parameter REG_W, default 4, giving the register index width.
REQ-003 The block SHALL have parameter NREQ, default 3, giving the requester count (0 = PC update, 1 = ALU writeback, 2 = test loader).
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester write request, held high until granted.
REQ-007 The block SHALL have port req_reg, input, NREQ*REG_W bits: packed target register index, slice i belonging to requester i.
REQ-008 The block SHALL have port req_data, input, NREQ*DATA_W bits: packed write data, slice i belonging to requester i.
REQ-009 The block SHALL have port gnt, output, NREQ bits: one-cycle grant pulse, at most one bit set.
REQ-010 The block SHALL have port wr_en, output, 1 bit: write strobe to the register bank.
REQ-011 The block SHALL have port wr_reg, output, REG_W bits: register index to write.
REQ-012 The block SHALL have port wr_data, output, DATA_W bits: data to write.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state WRITE.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits: saturating count of dropped writes to register 3.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and WRITE.
REQ-016 In IDLE with any req bit high, the block SHALL select a winner, pulse gnt[winner] for that cycle, register the winner's req_reg/req_data into wr_reg/wr_data, and enter WRITE on the next edge.
REQ-017 In IDLE with no req bit high, the block SHALL stay in IDLE with gnt all zero.
REQ-018 In WRITE, wr_en SHALL be high for exactly one cycle and the FSM SHALL return to IDLE unconditionally; a requests-to-strobe latency of 1 cycle and a sustained throughput of 1 write per 2 cycles result.
REQ-019 Default winner selection SHALL be round-robin: search starts at rr_ptr and wraps modulo NREQ; the first set req bit wins.
REQ-020 On each grant, rr_ptr SHALL become (winner+1) mod NREQ; rr_ptr SHALL be unchanged in cycles with no grant.
REQ-021 Requests arriving while in WRITE SHALL NOT be granted until the following IDLE cycle; requesters SHALL hold req, reg and data stable until gnt.
REQ-022 If the granted index equals 3 (constant-generator register), wr_en SHALL stay low in the WRITE cycle, gnt SHALL still pulse, and drop_cnt SHALL increment, saturating at 255.
REQ-023 wr_reg/wr_data SHALL hold their last value outside WRITE.

Reset
REQ-024 Asserting rst SHALL immediately force state IDLE, gnt=0, wr_en=0, busy=0, wr_reg=0, wr_data=0, drop_cnt=0 and rr_ptr=0.
REQ-025 A reset asserted during WRITE SHALL suppress that write, and the granted requester SHALL NOT receive a second grant for it.

Configuration
REQ-026 With macro REGARB_PC_PRIORITY_EN defined, requester 0 SHALL win whenever req[0] is high, regardless of rr_ptr, with round-robin applying among the others; without it, pure round-robin (REQ-019) SHALL apply to all requesters.

Structure
REQ-027 State encodings, the index-3 constant, and the requester-ID constants SHALL live in the shared CPU package.
REQ-028 Winner selection SHALL be a combinational sub-module rr_pick (inputs req, rr_ptr, priority enable; outputs valid, one-hot grant, index).

Verification
REQ-029 Test 1: req=001, reg=5, data=0xBEEF -> gnt=001 in cycle 0; wr_en=1, wr_reg=5, wr_data=0xBEEF in cycle 1.
REQ-030 Test 2: req=111 held, rr_ptr=0, macro off -> grant order 0,1,2,0, with one grant every 2 cycles.
REQ-031 Test 3: macro on, req=111 held, with requester 0 deasserting req[0] after each grant and re-raising it 1 cycle later -> requester 0 wins every IDLE cycle in which req[0] is high.
REQ-032 Test 4: 260 writes to register 3 -> wr_en never asserted, drop_cnt=255.
REQ-033 Test 5: rst asserted mid-WRITE -> wr_en=0 at once, all outputs at reset values, next grant goes to the lowest-index requester.
